// File: rtl/lv_rac_arb_pkg.sv
// Shared constants for the LV register-access arbiter slice, plus the CRC8
// helper used to protect read data returned to requesters.
//   LV_REG_AW / LV_REG_DW / LV_REG_CRC_W : register bank geometry
//   LV_RAC_NUM_REQ, RAC_ID_*             : requester count and fixed indices
//   crc16to8()                           : CRC8 (poly 0x07, init 0, MSB first)
//                                          over a 16-bit {1'b1, addr, data} word
package lv_rac_arb_pkg;

    localparam int unsigned LV_REG_AW      = 7;
    localparam int unsigned LV_REG_DW      = 8;
    localparam int unsigned LV_REG_CRC_W   = 8;

    localparam int unsigned LV_RAC_NUM_REQ = 3;
    localparam int unsigned RAC_ID_SPI     = 0;
    localparam int unsigned RAC_ID_OWT     = 1;
    localparam int unsigned RAC_ID_WDG     = 2;

    localparam int unsigned CRC_IN_W = 1 + LV_REG_AW + LV_REG_DW;
    localparam logic [LV_REG_CRC_W-1:0] CRC8_POLY = 8'h07;

    // Parallel form of the serial LFSR; the loop unrolls into XOR trees.
    function automatic logic [LV_REG_CRC_W-1:0] crc16to8(input logic [CRC_IN_W-1:0] din);
        logic [LV_REG_CRC_W-1:0] crc;
        logic [CRC_IN_W-1:0]     sh;
        logic                    fb;
        crc = '0;
        sh  = din;
        for (int unsigned i = 0; i < CRC_IN_W; i++) begin
            fb  = crc[LV_REG_CRC_W-1] ^ sh[CRC_IN_W-1];
            crc = {crc[LV_REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
            sh  = sh << 1;
        end
        return crc;
    endfunction

endpackage

// File: rtl/lv_rac_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : index granted last time; search starts at last_i+1 and wraps
//   vld_o  : at least one request is set
//   idx_o  : winning index (0 when vld_o is low)
module lv_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               vld_o,
    output logic [IW-1:0]      idx_o
);

    int unsigned k;
    logic [IW-1:0] kk;

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        k     = 0;
        kk    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k  = (32'(last_i) + 1 + i) % NUM_REQ;
            kk = IW'(k);
            if (!vld_o && req_i[kk]) begin
                vld_o = 1'b1;
                idx_o = kk;
            end
        end
    end

endmodule

// File: rtl/lv_rac_arb.sv
// Arbiter/sequencer for the single LV register-bank access port.
// Requesters (0 = SPI slave, 1 = OWT rx, 2 = wdg scan) are served round-robin
// with a level-req / single-cycle-ack handshake. Each access runs
// IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> RESP -> IDLE; all outputs registered.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_arb_en               : low blocks new grants (in-flight access completes)
//   i_req/i_wr/i_addr/i_wdata : per-requester request, direction, packed addr/data
//   o_ack                  : one-hot completion pulse, with o_rdata/o_rcrc/o_err
//   o_reg_*/i_reg_*        : register bank strobes, address, data, addr error
//   o_busy, o_grant_id     : state != IDLE, current or last granted index
// RD_LAT must be >= 1.
module lv_rac_arb
    import lv_rac_arb_pkg::*;
#(
    parameter int unsigned REG_AW    = LV_REG_AW,
    parameter int unsigned REG_DW    = LV_REG_DW,
    parameter int unsigned REG_CRC_W = LV_REG_CRC_W,
    parameter int unsigned NUM_REQ   = LV_RAC_NUM_REQ,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_arb_en,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_wr,
    input  logic [NUM_REQ*REG_AW-1:0]   i_addr,
    input  logic [NUM_REQ*REG_DW-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [REG_DW-1:0]           o_rdata,
    output logic [REG_CRC_W-1:0]        o_rcrc,
    output logic                        o_err,
    output logic                        o_reg_rd_en,
    output logic                        o_reg_wr_en,
    output logic [REG_AW-1:0]           o_reg_addr,
    output logic [REG_DW-1:0]           o_reg_wdata,
    input  logic [REG_DW-1:0]           i_reg_rdata,
    input  logic                        i_reg_addr_err,
    output logic                        o_busy,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic                 wr_q, wr_d;
    logic [REG_AW-1:0]    addr_q, addr_d;
    logic [REG_DW-1:0]    wdata_q, wdata_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [REG_DW-1:0]    rdata_q, rdata_d;
    logic [REG_CRC_W-1:0] crc_q, crc_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic                 sel_wr;
    logic [REG_AW-1:0]    sel_addr;
    logic [REG_DW-1:0]    sel_wdata;

    lv_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i  (i_req),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    // Mux out the winning requester's command fields.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IW'(k)) begin
                sel_wr    = i_wr[k];
                sel_addr  = i_addr[k*REG_AW +: REG_AW];
                sel_wdata = i_wdata[k*REG_DW +: REG_DW];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            gid_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            crc_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs are registered, so each one is computed for the state being
    // entered: strobes are set on IDLE->ISSUE, ack/err on WAIT->RESP.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        cnt_d   = cnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        crc_d   = crc_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_arb_en && pick_vld) begin
                    state_d = S_ISSUE;
                    last_d  = pick_idx;
                    gid_d   = pick_idx;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rd_en_d = !sel_wr;
                    wr_en_d = sel_wr;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d = S_RESP;
                    ack_d   = NUM_REQ'(1) << gid_q;
                    err_d   = i_reg_addr_err;
                    if (!wr_q) begin
                        rdata_d = i_reg_rdata;
                        crc_d   = crc16to8({1'b1, addr_q, i_reg_rdata});
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign o_ack       = ack_q;
    assign o_rdata     = rdata_q;
    assign o_rcrc      = crc_q;
    assign o_err       = err_q;
    assign o_reg_rd_en = rd_en_q;
    assign o_reg_wr_en = wr_en_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_busy      = busy_q;
    assign o_grant_id  = gid_q;

endmodule

// File: doc/lv_rac_arb.md
Name: lv_rac_arb

Overview:
- Arbiter and sequencer for the single LV register-bank access port, shared by NUM_REQ requesters: 0 = SPI slave, 1 = OWT rx, 2 = wdg scan.
- Grants requesters round-robin and drives one read or write strobe to the register bank.
- For reads, returns the read data plus a CRC8 computed over {1'b1, addr, data}.
- Every requester sees the same level-req / single-cycle-ack handshake that the wdg scan logic already uses.

Parameters:
- REG_AW, 7, register address width.
- REG_DW, 8, register data width.
- REG_CRC_W, 8, CRC width.
- NUM_REQ, 3, number of requesters.
- RD_LAT, 1, register-bank read latency in cycles, counted from the strobe cycle. Must be >= 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_arb_en  in  1  arbitration enable; low = no new grants.
- i_req  in  NUM_REQ  level request per requester.
- i_wr  in  NUM_REQ  1 = write, 0 = read, per requester.
- i_addr  in  NUM_REQ*REG_AW  packed addresses; requester k occupies slice k.
- i_wdata  in  NUM_REQ*REG_DW  packed write data.
- o_ack  out  NUM_REQ  one-hot, single-cycle completion pulse.
- o_rdata  out  REG_DW  read data, valid with ack.
- o_rcrc  out  REG_CRC_W  CRC of read data, valid with ack.
- o_err  out  1  address error, pulses with ack.
- o_reg_rd_en  out  1  bank read strobe.
- o_reg_wr_en  out  1  bank write strobe.
- o_reg_addr  out  REG_AW  bank address.
- o_reg_wdata  out  REG_DW  bank write data.
- i_reg_rdata  in  REG_DW  bank read data.
- i_reg_addr_err  in  1  bank flags an unmapped address; sampled together with rdata.
- o_busy  out  1  state != IDLE.
- o_grant_id  out  $clog2(NUM_REQ)  current or last grant index.

Behaviour:
- Clocking and reset: single clock i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first).
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
- IDLE:
  - If i_arb_en & |i_req, pick the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Latch grant index, wr, addr and wdata; update last_grant and o_grant_id; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (cycle 1):
  - Exactly one of o_reg_rd_en / o_reg_wr_en is high, for one cycle.
  - o_reg_addr and o_reg_wdata are held from ISSUE until the next grant.
- WAIT: lasts RD_LAT cycles. At the end of the last WAIT cycle (cycle 1+RD_LAT), sample i_reg_rdata and i_reg_addr_err.
- Read path:
  - Register o_rdata = sampled rdata.
  - Register o_rcrc = crc16to8({1'b1, latched addr, rdata}).
- Write path:
  - o_rdata and o_rcrc keep their previous values.
  - o_err = sampled i_reg_addr_err.
- RESP (cycle 2+RD_LAT): o_ack[grant] = 1 for exactly one cycle, together with o_err; then return to IDLE.
- Total latency: request seen at cycle 0 -> ack at cycle 2+RD_LAT. With RD_LAT = 1, ack at cycle 3 and the next grant at cycle 4.
- Handshake rules:
  - A requester clears req on the cycle it sees ack.
  - The arbiter samples i_req only in IDLE, which is always at least one cycle after ack, so a stale re-grant is impossible.
- Request withdrawn before grant: never granted, no ack.
- Request withdrawn after grant: the access completes and ack still pulses.
- i_arb_en dropped mid-access: the current access completes normally; no new grant is made until enable returns.
- Simultaneous requests: strict round-robin. A requester that holds req continuously cannot starve another; grants alternate.
- Reset asserted mid-access: strobes and ack drop immediately. No ack is generated for the aborted access.

Decomposition:
- REG_AW, REG_DW and REG_CRC_W stay in the shared lv_param.svh.
- Add LV_RAC_NUM_REQ and requester index constants (RAC_ID_SPI = 0, RAC_ID_OWT = 1, RAC_ID_WDG = 2) to lv_param.svh.
- The state enum is a local typedef.
- Reuse the existing crc16to8_parallel for the CRC.
- One new sub-module is natural: lv_rr_pick, a combinational round-robin picker with inputs req and last and outputs grant-valid and index.

Test Plan:
- Reset, then requester 2 reads addr 7'h01 with bank returning 8'hA5 (RD_LAT = 1) -> o_reg_rd_en at cycle 1 with addr 7'h01; o_ack = 3'b100 at cycle 3; o_rdata = 8'hA5; o_rcrc = crc16to8({1'b1, 7'h01, 8'hA5}).
- All three requesters assert at the same cycle after reset -> acks in order 001, 010, 100, 4 cycles apart; o_busy stays high throughout except for the single IDLE cycle between accesses.
- Requester 0 re-requests immediately after every ack while requester 1 holds req -> grants alternate 0, 1, 0, 1; requester 1 is never skipped.
- Requester 1 writes 8'h3C to 7'h0B and the bank asserts i_reg_addr_err -> o_reg_wr_en for one cycle with wdata 8'h3C; ack and o_err pulse together; o_rdata unchanged.
- i_arb_en deasserted during WAIT with requester 0 pending -> the current ack still arrives; no ISSUE occurs while disabled; requester 0 is granted one cycle after re-enable.
- i_rst asserted during WAIT -> all outputs 0 immediately; no ack. After release, requester 0 wins first.
